// File: rtl/sprite_mem_arbiter_pkg.sv
// Shared types and constants for the sprite memory arbiter and its helpers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: requester indices, FSM encoding, address/data widths, RAM command struct.
package sprite_mem_arbiter_pkg;

    localparam int ADDR_W  = 9;
    localparam int DATA_W  = 16;
    localparam int NUM_REQ = 3;

    typedef logic [ADDR_W-1:0]  addr_t;
    typedef logic [DATA_W-1:0]  data_t;
    typedef logic [NUM_REQ-1:0] req_vec_t;
    typedef logic [1:0]         req_idx_t;

    // Requester indices: line image loader, location loader, CPU port.
    localparam req_idx_t REQ_IMG = 2'd0;
    localparam req_idx_t REQ_LOC = 2'd1;
    localparam req_idx_t REQ_CPU = 2'd2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } arb_state_t;

    // One RAM access as seen by the port register stage.
    typedef struct packed {
        logic  en;
        logic  we;
        addr_t addr;
        data_t wdata;
    } mem_cmd_t;

    function automatic req_vec_t req_onehot(input req_idx_t idx);
        req_vec_t oh;
        oh = '0;
        case (idx)
            REQ_IMG: oh = 3'b001;
            REQ_LOC: oh = 3'b010;
            REQ_CPU: oh = 3'b100;
            default: oh = '0;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/sprite_mem_arbiter_rr_pick.sv
// Round-robin choice between the location loader (1) and the CPU port (2).
// Latency: combinational.
// Backpressure: none; caller only uses pick when at least one request is high.
// Ports: req_1, req_2 = requests; last = 0 if requester 1 was served last,
//        1 if requester 2; pick = 0 selects requester 1, 1 selects requester 2.
module sprite_rr_pick (
    input  logic req_1,
    input  logic req_2,
    input  logic last,
    output logic pick
);

    always_comb begin
        pick = 1'b0;
        if (req_1 && req_2) begin
            // Both competing: favour the one that was not served last.
            pick = ~last;
        end else begin
            pick = req_2;
        end
    end

endmodule

// File: rtl/sprite_mem_arbiter.sv
// Three-way arbiter for the single-port sprite RAM: image loader has absolute priority,
// Latency: grant 1 cycle after request; RAM command 1 cycle after access; rvalid 2 cycles after access.
// Backpressure: requesters hold req until served; bursts of 1/2 are capped at MAX_BURST cycles.
// Ports: clk/rst (sync, active-high); req_i/addr_i requests; we_1/2, wdata_1/2 write side;
//        gnt one-hot owner; mem_en/mem_we/mem_addr/mem_wdata registered RAM command;
//        mem_rdata RAM return; rvalid per-requester read strobe, rdata = mem_rdata.
module sprite_mem_arbiter
    import sprite_mem_arbiter_pkg::*;
#(
    parameter int MAX_BURST = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_0,
    input  logic              req_1,
    input  logic              req_2,
    input  logic [ADDR_W-1:0] addr_0,
    input  logic [ADDR_W-1:0] addr_1,
    input  logic [ADDR_W-1:0] addr_2,
    input  logic              we_1,
    input  logic              we_2,
    input  logic [DATA_W-1:0] wdata_1,
    input  logic [DATA_W-1:0] wdata_2,
    output logic [2:0]        gnt,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [2:0]        rvalid,
    output logic [DATA_W-1:0] rdata
);

    // Last burst_cnt value at which a requester 1/2 may still keep the port.
    localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

    arb_state_t state, state_nxt;
    req_idx_t   owner, owner_nxt;
    logic [3:0] burst_cnt, burst_cnt_nxt;
    logic       rr_last, rr_last_nxt;
    req_vec_t   gnt_nxt;
    logic       rr_pick;
    logic       owner_req;
    logic       cont;
    mem_cmd_t   acc;
    req_vec_t   tag_s1;

    sprite_rr_pick u_rr_pick (
        .req_1 (req_1),
        .req_2 (req_2),
        .last  (rr_last),
        .pick  (rr_pick)
    );

    // Request line of whoever currently owns the port.
    always_comb begin
        owner_req = 1'b0;
        case (owner)
            REQ_IMG: owner_req = req_0;
            REQ_LOC: owner_req = req_1;
            REQ_CPU: owner_req = req_2;
            default: owner_req = 1'b0;
        endcase
    end

    // Next-owner decision.
    always_comb begin
        state_nxt     = ST_IDLE;
        owner_nxt     = owner;
        burst_cnt_nxt = '0;
        rr_last_nxt   = rr_last;
        cont          = 1'b0;
        if (req_0) begin
            // Display deadline: the image loader always wins and is never capped.
            state_nxt = ST_OWN;
            owner_nxt = REQ_IMG;
            cont      = (state == ST_OWN) && (owner == REQ_IMG);
        end else if ((state == ST_OWN) && (owner != REQ_IMG) && owner_req &&
                     (burst_cnt < BURST_LAST)) begin
            state_nxt = ST_OWN;
            cont      = 1'b1;
        end else if (req_1 || req_2) begin
            // Fresh grant, even when the same requester wins again after its
            // burst expired, so the burst count restarts.
            state_nxt   = ST_OWN;
            owner_nxt   = rr_pick ? REQ_CPU : REQ_LOC;
            rr_last_nxt = rr_pick;
        end
        if (cont) begin
            // Saturate so a long image-loader burst cannot wrap the counter.
            burst_cnt_nxt = (burst_cnt == 4'hF) ? burst_cnt : burst_cnt + 4'd1;
        end
        gnt_nxt = (state_nxt == ST_OWN) ? req_onehot(owner_nxt) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            owner     <= REQ_IMG;
            burst_cnt <= '0;
            rr_last   <= 1'b1;  // pretend requester 2 went last: requester 1 is first in line
            gnt       <= '0;
        end else begin
            state     <= state_nxt;
            owner     <= owner_nxt;
            burst_cnt <= burst_cnt_nxt;
            rr_last   <= rr_last_nxt;
            gnt       <= gnt_nxt;
        end
    end

    // Access of the current owner; a grant cycle with its req dropped is empty.
    always_comb begin
        acc.en    = (state == ST_OWN) && owner_req;
        acc.we    = 1'b0;
        acc.addr  = addr_0;
        acc.wdata = mem_wdata;  // image loader is read-only: leave write data untouched
        case (owner)
            REQ_LOC: begin
                acc.we    = we_1;
                acc.addr  = addr_1;
                acc.wdata = wdata_1;
            end
            REQ_CPU: begin
                acc.we    = we_2;
                acc.addr  = addr_2;
                acc.wdata = wdata_2;
            end
            default: ;
        endcase
    end

    // RAM command register plus a two-stage read tag that travels with the
    // access, so returns are attributed correctly regardless of later grants.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            tag_s1    <= '0;
            rvalid    <= '0;
        end else begin
            mem_en <= acc.en;
            mem_we <= acc.en && acc.we;
            if (acc.en) begin
                mem_addr  <= acc.addr;
                mem_wdata <= acc.wdata;
            end
            tag_s1 <= (acc.en && !acc.we) ? gnt : '0;
            rvalid <= tag_s1;
        end
    end

    assign rdata = mem_rdata;

endmodule

// File: tb/tb_sprite_mem_arbiter.sv
module tb_sprite_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        req_0, req_1, req_2;
    logic [8:0]  addr_0, addr_1, addr_2;
    logic        we_1, we_2;
    logic [15:0] wdata_1, wdata_2;
    logic [2:0]  gnt;
    logic        mem_en, mem_we;
    logic [8:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic [2:0]  rvalid;
    logic [15:0] rdata;

    int checks = 0;
    int errors = 0;

    sprite_mem_arbiter #(.MAX_BURST(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_0     (req_0),
        .req_1     (req_1),
        .req_2     (req_2),
        .addr_0    (addr_0),
        .addr_1    (addr_1),
        .addr_2    (addr_2),
        .we_1      (we_1),
        .we_2      (we_2),
        .wdata_1   (wdata_1),
        .wdata_2   (wdata_2),
        .gnt       (gnt),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .rvalid    (rvalid),
        .rdata     (rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One row: inputs held during a cycle, outputs expected just after its closing edge.
    typedef struct {
        logic        rst;
        logic [2:0]  req;      // {req_2, req_1, req_0}
        logic [8:0]  a0, a1, a2;
        logic        we1, we2;
        logic [15:0] wd1, wd2, rd;
        logic [2:0]  e_gnt;
        logic        e_en, e_we;
        logic [8:0]  e_addr;
        logic [15:0] e_wdata;
        logic [2:0]  e_rvalid;
    } vec_t;

    vec_t tbl[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req_0 = 0; req_1 = 0; req_2 = 0;
        addr_0 = '0; addr_1 = '0; addr_2 = '0;
        we_1 = 0; we_2 = 0; wdata_1 = '0; wdata_2 = '0;
        mem_rdata = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        step();
        rst = 0;
    endtask

    initial begin
        rst = 1;
        clear_inputs();

        //        rst req     a0      a1      a2      we1 we2 wd1 wd2       rd         gnt     en we addr    wdata      rvalid
        tbl[0]  = '{1, 3'b000, 9'h000, 9'h000, 9'h000, 0, 0, 16'h0, 16'h0,    16'h0000, 3'b000, 0, 0, 9'h000, 16'h0000, 3'b000};
        // requester 1: three reads at 0x010..0x012
        tbl[1]  = '{0, 3'b010, 9'h000, 9'h010, 9'h000, 0, 0, 16'h0, 16'h0,    16'h0000, 3'b010, 0, 0, 9'h000, 16'h0000, 3'b000};
        tbl[2]  = '{0, 3'b010, 9'h000, 9'h010, 9'h000, 0, 0, 16'h0, 16'h0,    16'h0000, 3'b010, 1, 0, 9'h010, 16'h0000, 3'b000};
        tbl[3]  = '{0, 3'b010, 9'h000, 9'h011, 9'h000, 0, 0, 16'h0, 16'h0,    16'h1111, 3'b010, 1, 0, 9'h011, 16'h0000, 3'b010};
        tbl[4]  = '{0, 3'b010, 9'h000, 9'h012, 9'h000, 0, 0, 16'h0, 16'h0,    16'h2222, 3'b010, 1, 0, 9'h012, 16'h0000, 3'b010};
        tbl[5]  = '{0, 3'b000, 9'h000, 9'h012, 9'h000, 0, 0, 16'h0, 16'h0,    16'h3333, 3'b000, 0, 0, 9'h012, 16'h0000, 3'b010};
        tbl[6]  = '{0, 3'b000, 9'h000, 9'h000, 9'h000, 0, 0, 16'h0, 16'h0,    16'h0000, 3'b000, 0, 0, 9'h012, 16'h0000, 3'b000};
        // requester 2: write 0xBEEF to 0x1FF, no read return
        tbl[7]  = '{0, 3'b100, 9'h000, 9'h000, 9'h1FF, 0, 1, 16'h0, 16'hBEEF, 16'h0000, 3'b100, 0, 0, 9'h012, 16'h0000, 3'b000};
        tbl[8]  = '{0, 3'b100, 9'h000, 9'h000, 9'h1FF, 0, 1, 16'h0, 16'hBEEF, 16'h0000, 3'b100, 1, 1, 9'h1FF, 16'hBEEF, 3'b000};
        tbl[9]  = '{0, 3'b000, 9'h000, 9'h000, 9'h000, 0, 0, 16'h0, 16'h0,    16'h0000, 3'b000, 0, 0, 9'h1FF, 16'hBEEF, 3'b000};
        tbl[10] = '{0, 3'b000, 9'h000, 9'h000, 9'h000, 0, 0, 16'h0, 16'h0,    16'h0000, 3'b000, 0, 0, 9'h1FF, 16'hBEEF, 3'b000};
        // requester 0: single read at 0x055
        tbl[11] = '{0, 3'b001, 9'h055, 9'h000, 9'h000, 0, 0, 16'h0, 16'h0,    16'h0000, 3'b001, 0, 0, 9'h1FF, 16'hBEEF, 3'b000};
        tbl[12] = '{0, 3'b001, 9'h055, 9'h000, 9'h000, 0, 0, 16'h0, 16'h0,    16'h0000, 3'b001, 1, 0, 9'h055, 16'hBEEF, 3'b000};
        tbl[13] = '{0, 3'b000, 9'h000, 9'h000, 9'h000, 0, 0, 16'h0, 16'h0,    16'hABCD, 3'b000, 0, 0, 9'h055, 16'hBEEF, 3'b001};
        tbl[14] = '{0, 3'b000, 9'h000, 9'h000, 9'h000, 0, 0, 16'h0, 16'h0,    16'h0000, 3'b000, 0, 0, 9'h055, 16'hBEEF, 3'b000};

        for (int i = 0; i < 15; i++) begin
            rst       = tbl[i].rst;
            req_0     = tbl[i].req[0];
            req_1     = tbl[i].req[1];
            req_2     = tbl[i].req[2];
            addr_0    = tbl[i].a0;
            addr_1    = tbl[i].a1;
            addr_2    = tbl[i].a2;
            we_1      = tbl[i].we1;
            we_2      = tbl[i].we2;
            wdata_1   = tbl[i].wd1;
            wdata_2   = tbl[i].wd2;
            mem_rdata = tbl[i].rd;
            step();
            check($sformatf("vec%0d_gnt", i),    gnt,       tbl[i].e_gnt);
            check($sformatf("vec%0d_en", i),     mem_en,    tbl[i].e_en);
            check($sformatf("vec%0d_we", i),     mem_we,    tbl[i].e_we);
            check($sformatf("vec%0d_addr", i),   mem_addr,  tbl[i].e_addr);
            check($sformatf("vec%0d_wdata", i),  mem_wdata, tbl[i].e_wdata);
            check($sformatf("vec%0d_rvalid", i), rvalid,    tbl[i].e_rvalid);
            check($sformatf("vec%0d_rdata", i),  rdata,     tbl[i].rd);
        end

        // Requesters 1 and 2 both held: 8-cycle blocks, requester 1 first, no gaps.
        do_reset();
        req_1 = 1; req_2 = 1;
        for (int k = 0; k < 48; k++) begin
            step();
            check($sformatf("rr_gnt_c%0d", k), gnt, (((k / 8) % 2) == 0) ? 3'b010 : 3'b100);
        end
        clear_inputs();
        step();
        step();

        // Preemption by requester 0 on the third cycle of a requester-1 burst.
        do_reset();
        req_1 = 1; addr_1 = 9'h030;
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("pre_gnt_c%0d", k), gnt, 3'b010);
        end
        req_0 = 1;
        step();
        check("preempt_gnt", gnt, 3'b001);
        step();
        check("preempt_hold", gnt, 3'b001);
        req_0 = 0;
        step();
        check("regrant_gnt", gnt, 3'b010);
        // A restarted burst count gives requester 1 a full 8 cycles before 2 gets in.
        req_2 = 1;
        for (int k = 1; k < 8; k++) begin
            step();
            check($sformatf("regrant_burst_c%0d", k), gnt, 3'b010);
        end
        step();
        check("regrant_burst_end", gnt, 3'b100);
        clear_inputs();
        step();
        step();

        // Reset in the middle of a two-read image-loader burst.
        do_reset();
        req_0 = 1; addr_0 = 9'h020;
        step();
        check("rstmid_gnt", gnt, 3'b001);
        step();
        check("rstmid_en1", mem_en, 1'b1);
        check("rstmid_addr1", mem_addr, 9'h020);
        addr_0 = 9'h021;
        rst = 1;
        step();
        check("rstmid_gnt0", gnt, 3'b000);
        check("rstmid_en0", mem_en, 1'b0);
        check("rstmid_we0", mem_we, 1'b0);
        check("rstmid_addr0", mem_addr, 9'h000);
        check("rstmid_wdata0", mem_wdata, 16'h0000);
        check("rstmid_rvalid0", rvalid, 3'b000);
        rst = 0;
        step();
        check("rstmid_regrant", gnt, 3'b001);
        check("rstmid_rvalid1", rvalid, 3'b000);
        check("rstmid_en_after", mem_en, 1'b0);
        req_0 = 0;
        step();
        check("rstmid_rvalid2", rvalid, 3'b000);
        check("rstmid_idle", gnt, 3'b000);
        step();
        check("rstmid_rvalid3", rvalid, 3'b000);

        // Long image-loader burst is never cut; requester 1 follows immediately.
        do_reset();
        req_0 = 1; req_1 = 1;
        for (int k = 0; k < 40; k++) begin
            step();
            check($sformatf("long0_gnt_c%0d", k), gnt, 3'b001);
        end
        req_0 = 0;
        step();
        check("long0_handover", gnt, 3'b010);
        clear_inputs();
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
